// File: rtl/branch_redirect_ctrl.sv
// EX-stage misprediction detection, wrong-path flush and registered PC redirect toward IF.
// Optional branch statistics counters are built only when BRANCH_PERF_CNT_EN is defined.
module branch_redirect_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic             ex_hold,
  input  logic             ex_is_b_type,
  input  logic             ex_is_jal,
  input  logic             ex_is_jalr,
  input  logic             ex_branch_taken,
  input  logic             ex_pred_taken,
  input  logic [XLEN-1:0]  ex_pred_target,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_target,
  input  logic             redirect_ready,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             busy,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispred_count
);

  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

  state_t          state;
  state_t          state_nxt;
  logic            resolved;
  logic            cf;
  logic            act_taken;
  logic            mis;
  logic [XLEN-1:0] next_pc;

  assign cf        = ex_valid & (ex_is_b_type | ex_is_jal | ex_is_jalr);
  assign act_taken = ex_is_jal | ex_is_jalr | ex_branch_taken;
  assign next_pc   = act_taken ? ex_target : ex_pc + XLEN'(4);
  assign mis       = cf & ~resolved &
                     ((act_taken != ex_pred_taken) | (act_taken & (ex_pred_target != ex_target)));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mis) state_nxt = PEND;
      PEND:    if (redirect_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // In PEND, EX holds wrong-path or bubble content, so only IF/ID keeps being killed.
  assign flush_id_ex = mis & (state == IDLE);
  assign flush_if_id = mis | (state == PEND);
  assign busy        = (state == PEND);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      resolved       <= 1'b0;
    end else begin
      state          <= state_nxt;
      redirect_valid <= (state_nxt == PEND);
      if ((state == IDLE) && mis)
        redirect_pc <= next_pc;
      // A stalled branch re-presented by EX must not redirect a second time.
      resolved <= ex_hold & (resolved | mis);
    end
  end

`ifdef BRANCH_PERF_CNT_EN
  logic [CNT_W-1:0] br_cnt_q;
  logic [CNT_W-1:0] mis_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      if (cf & ~ex_hold)
        br_cnt_q <= br_cnt_q + CNT_W'(1);
      if (mis & (state == IDLE))
        mis_cnt_q <= mis_cnt_q + CNT_W'(1);
    end
  end

  assign br_count      = br_cnt_q;
  assign mispred_count = mis_cnt_q;
`else
  assign br_count      = '0;
  assign mispred_count = '0;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Self-checking bench for branch_redirect_ctrl: directed spec scenarios plus randomized
// traffic against a cycle-level behavioural model of the redirect protocol.
module tb_branch_redirect_ctrl;

  localparam int XLEN  = 32;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             ex_valid, ex_hold, ex_is_b_type, ex_is_jal, ex_is_jalr;
  logic             ex_branch_taken, ex_pred_taken;
  logic [XLEN-1:0]  ex_pred_target, ex_pc, ex_target;
  logic             redirect_ready;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;
  logic             flush_if_id, flush_id_ex, busy;
  logic [CNT_W-1:0] br_count, mispred_count;

  int total = 0;
  int bad   = 0;

  // Behavioural model: one outstanding redirect, its PC, the stall guard and event counts.
  bit              m_pend;
  bit [XLEN-1:0]   m_pc;
  bit              m_res;
  bit [CNT_W-1:0]  m_br;
  bit [CNT_W-1:0]  m_mis;

  always #5 clk = ~clk;

  branch_redirect_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_hold(ex_hold),
    .ex_is_b_type(ex_is_b_type), .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr),
    .ex_branch_taken(ex_branch_taken), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target), .ex_pc(ex_pc), .ex_target(ex_target),
    .redirect_ready(redirect_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .busy(busy),
    .br_count(br_count), .mispred_count(mispred_count)
  );

  function automatic bit is_cf();
    return ex_valid && (ex_is_b_type || ex_is_jal || ex_is_jalr);
  endfunction

  function automatic bit m_taken();
    return ex_is_jal || ex_is_jalr || ex_branch_taken;
  endfunction

  function automatic bit model_mis();
    bit wrong_dir, wrong_tgt;
    wrong_dir = (m_taken() != ex_pred_taken);
    wrong_tgt = m_taken() && (ex_pred_target != ex_target);
    return is_cf() && !m_res && (wrong_dir || wrong_tgt);
  endfunction

  function automatic bit [XLEN-1:0] model_next_pc();
    bit [XLEN:0] seq;
    seq = {1'b0, ex_pc} + 33'd4;
    return m_taken() ? ex_target : seq[XLEN-1:0];
  endfunction

  function automatic bit [CNT_W-1:0] exp_br();
`ifdef BRANCH_PERF_CNT_EN
    return m_br;
`else
    return '0;
`endif
  endfunction

  function automatic bit [CNT_W-1:0] exp_mis();
`ifdef BRANCH_PERF_CNT_EN
    return m_mis;
`else
    return '0;
`endif
  endfunction

  always @(posedge clk) begin
    bit mis_now;
    mis_now = model_mis();
    if (rst) begin
      m_pend = 0; m_pc = '0; m_res = 0; m_br = '0; m_mis = '0;
    end else begin
      if (is_cf() && !ex_hold) m_br = m_br + 1;
      if (m_pend) begin
        if (redirect_ready) m_pend = 0;
      end else if (mis_now) begin
        m_pend = 1;
        m_pc   = model_next_pc();
        m_mis  = m_mis + 1;
      end
      m_res = ex_hold && (m_res || mis_now);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ex_valid = 0; ex_hold = 0; ex_is_b_type = 0; ex_is_jal = 0; ex_is_jalr = 0;
    ex_branch_taken = 0; ex_pred_taken = 0;
    ex_pred_target = '0; ex_pc = '0; ex_target = '0;
    redirect_ready = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    tick(); tick();
    rst = 0;
    #3;
    total++;
    if (redirect_valid !== 1'b0 || redirect_pc !== '0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_regs: valid=%b pc=%h busy=%b, required 0/0/0", redirect_valid, redirect_pc, busy);
    end
    total++;
    if (flush_if_id !== 1'b0 || flush_id_ex !== 1'b0 || br_count !== '0 || mispred_count !== '0) begin
      bad++;
      $display("FAIL reset_flush_cnt: fif=%b fid=%b br=%0d mis=%0d, required all 0",
               flush_if_id, flush_id_ex, br_count, mispred_count);
    end
    tick();
  endtask

  task automatic test_beq_taken();
    clear_inputs();
    ex_valid = 1; ex_is_b_type = 1; ex_branch_taken = 1; ex_pred_taken = 0;
    ex_pc = 32'h100; ex_target = 32'h140;
    #3;
    total++;
    if (flush_if_id !== 1'b1 || flush_id_ex !== 1'b1) begin
      bad++;
      $display("FAIL beq_flush: fif=%b fid=%b, required 1/1", flush_if_id, flush_id_ex);
    end
    tick();
    clear_inputs();
    #3;
    total++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h140 || busy !== 1'b1) begin
      bad++;
      $display("FAIL beq_redirect: valid=%b pc=%h busy=%b, required 1/00000140/1", redirect_valid, redirect_pc, busy);
    end
    tick();
    #3;
    total++;
    if (busy !== 1'b0 || redirect_valid !== 1'b0) begin
      bad++;
      $display("FAIL beq_release: busy=%b valid=%b, required 0/0", busy, redirect_valid);
    end
    tick();
  endtask

  task automatic test_pc_wrap();
    clear_inputs();
    ex_valid = 1; ex_is_b_type = 1; ex_branch_taken = 0; ex_pred_taken = 1;
    ex_pc = 32'hFFFF_FFFC; ex_target = 32'h80; ex_pred_target = 32'h80;
    tick();
    clear_inputs();
    #3;
    total++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0) begin
      bad++;
      $display("FAIL bne_wrap: valid=%b pc=%h, required 1/00000000", redirect_valid, redirect_pc);
    end
    tick(); tick();
  endtask

  task automatic test_jalr_target();
    clear_inputs();
    ex_valid = 1; ex_is_jalr = 1; ex_pred_taken = 1;
    ex_pc = 32'h50; ex_pred_target = 32'h200; ex_target = 32'h204;
    #3;
    total++;
    if (flush_id_ex !== 1'b1) begin
      bad++;
      $display("FAIL jalr_flush: fid=%b, required 1", flush_id_ex);
    end
    tick();
    clear_inputs();
    #3;
    total++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h204) begin
      bad++;
      $display("FAIL jalr_redirect: valid=%b pc=%h, required 1/00000204", redirect_valid, redirect_pc);
    end
    tick(); tick();
  endtask

  task automatic test_ready_stall();
    clear_inputs();
    ex_valid = 1; ex_is_b_type = 1; ex_branch_taken = 1; ex_pc = 32'h100; ex_target = 32'h300;
    redirect_ready = 0;
    tick();
    for (int i = 0; i < 3; i++) begin
      ex_target = 32'h400 + 32'(i * 4);
      redirect_ready = 0;
      #3;
      total++;
      if (redirect_valid !== 1'b1 || busy !== 1'b1 || flush_if_id !== 1'b1 ||
          flush_id_ex !== 1'b0 || redirect_pc !== 32'h300) begin
        bad++;
        $display("FAIL stall_hold[%0d]: valid=%b busy=%b fif=%b fid=%b pc=%h, required 1/1/1/0/00000300",
                 i, redirect_valid, busy, flush_if_id, flush_id_ex, redirect_pc);
      end
      tick();
    end
    clear_inputs();
    tick();
    #3;
    total++;
    if (redirect_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL stall_release: valid=%b busy=%b, required 0/0", redirect_valid, busy);
    end
    tick();
  endtask

  task automatic test_hold_once();
    logic [CNT_W-1:0] br0, mis0;
    int pulses;
    bit prev;
    clear_inputs();
    br0 = br_count; mis0 = mispred_count;
    pulses = 0; prev = 0;
    ex_valid = 1; ex_is_b_type = 1; ex_branch_taken = 1; ex_pc = 32'h600; ex_target = 32'h700;
    for (int c = 0; c < 8; c++) begin
      ex_hold = (c < 4);
      if (c >= 5) ex_valid = 0;
      #3;
      if (redirect_valid && !prev) pulses++;
      prev = redirect_valid;
      tick();
    end
    total++;
    if (pulses !== 1) begin
      bad++;
      $display("FAIL hold_once: redirects=%0d, required 1", pulses);
    end
    total++;
`ifdef BRANCH_PERF_CNT_EN
    if (mispred_count - mis0 !== 1 || br_count - br0 !== 1) begin
`else
    if (mispred_count !== '0 || br_count !== '0) begin
`endif
      bad++;
      $display("FAIL hold_counters: dmis=%0d dbr=%0d", mispred_count - mis0, br_count - br0);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    ex_valid = 1; ex_is_jal = 1; ex_pred_taken = 0; ex_pc = 32'h10; ex_target = 32'h900;
    tick();
    clear_inputs();
    tick();
    ex_valid = 1; ex_is_b_type = 1; ex_branch_taken = 0; ex_pred_taken = 1;
    ex_pc = 32'h904; ex_target = 32'hA00; ex_pred_target = 32'hA00;
    #3;
    total++;
    if (flush_id_ex !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_flush: fid=%b busy=%b, required 1/0", flush_id_ex, busy);
    end
    tick();
    clear_inputs();
    #3;
    total++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h908) begin
      bad++;
      $display("FAIL b2b_redirect: valid=%b pc=%h, required 1/00000908", redirect_valid, redirect_pc);
    end
    tick(); tick();
  endtask

  task automatic test_reset_in_pend();
    clear_inputs();
    ex_valid = 1; ex_is_b_type = 1; ex_branch_taken = 1; ex_pc = 32'h20; ex_target = 32'h40;
    redirect_ready = 0;
    tick();
    clear_inputs();
    redirect_ready = 0;
    rst = 1;
    tick();
    rst = 0;
    #3;
    total++;
    if (redirect_valid !== 1'b0 || busy !== 1'b0 || br_count !== '0 || mispred_count !== '0) begin
      bad++;
      $display("FAIL rst_pend: valid=%b busy=%b br=%0d mis=%0d, required 0/0/0/0",
               redirect_valid, busy, br_count, mispred_count);
    end
    tick();
  endtask

  task automatic test_random();
    logic [XLEN-1:0] tgts [4];
    tgts[0] = 32'h1000; tgts[1] = 32'h2000; tgts[2] = 32'hFFFF_FFFC; tgts[3] = 32'h0000_0004;
    for (int c = 0; c < 400; c++) begin
      rst             = ($urandom_range(0, 59) == 0);
      ex_valid        = ($urandom_range(0, 3) != 0);
      ex_hold         = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0: begin ex_is_b_type = 1; ex_is_jal = 0; ex_is_jalr = 0; end
        1: begin ex_is_b_type = 0; ex_is_jal = 1; ex_is_jalr = 0; end
        2: begin ex_is_b_type = 0; ex_is_jal = 0; ex_is_jalr = 1; end
        default: begin ex_is_b_type = 0; ex_is_jal = 0; ex_is_jalr = 0; end
      endcase
      ex_branch_taken = ex_is_b_type & 1'($urandom_range(0, 1));
      ex_pred_taken   = 1'($urandom_range(0, 1));
      ex_pc           = tgts[$urandom_range(0, 3)];
      ex_target       = tgts[$urandom_range(0, 3)];
      ex_pred_target  = ($urandom_range(0, 1) != 0) ? ex_target : tgts[$urandom_range(0, 3)];
      redirect_ready  = ($urandom_range(0, 2) != 0);
      #3;
      total++;
      if (flush_id_ex !== (model_mis() && !m_pend) || flush_if_id !== (model_mis() || m_pend) ||
          redirect_valid !== m_pend || busy !== m_pend || redirect_pc !== m_pc ||
          br_count !== exp_br() || mispred_count !== exp_mis()) begin
        bad++;
        $display("FAIL rand[%0d]: fid=%b fif=%b v=%b busy=%b pc=%h br=%0d mis=%0d | want fid=%b fif=%b v=%b pc=%h br=%0d mis=%0d",
                 c, flush_id_ex, flush_if_id, redirect_valid, busy, redirect_pc, br_count, mispred_count,
                 model_mis() && !m_pend, model_mis() || m_pend, m_pend, m_pc, exp_br(), exp_mis());
      end
      tick();
    end
    rst = 0;
    clear_inputs();
    tick();
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    #1;
    test_reset();
    test_beq_taken();
    test_pc_wrap();
    test_jalr_target();
    test_ready_stall();
    test_hold_once();
    test_back_to_back();
    test_reset_in_pend();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_redirect_ctrl.md
# branch_redirect_ctrl

Sequences control-flow resolution in the EX stage of the RV32I 5-stage pipeline. It takes the resolved branch outcome from the branch comparator, together with jump and prediction information, and detects a misprediction. On a misprediction it flushes the wrong-path IF/ID and ID/EX contents and holds a registered PC redirect toward IF until fetch accepts it. It sits between the EX stage and the fetch/hazard unit and optionally counts branch statistics.

## Interface
- Parameters:
- `XLEN`, 32, datapath and PC width.
- `CNT_W`, 32, width of the performance counters.
- Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ex_valid`  in  1  the EX stage holds a real instruction (not a bubble).
- `ex_hold`  in  1  EX is stalled; the same instruction is presented again next cycle.
- `ex_is_b_type`  in  1  conditional branch in EX.
- `ex_is_jal`, `ex_is_jalr`  in  1 each  unconditional jumps in EX.
- `ex_branch_taken`  in  1  comparator result, already gated by `is_b_type`.
- `ex_pred_taken`  in  1  fetch-time prediction for this instruction.
- `ex_pred_target`  in  XLEN  fetch-time predicted target.
- `ex_pc`  in  XLEN  PC of the EX instruction.
- `ex_target`  in  XLEN  computed target (jalr target already has bit 0 cleared).
- `redirect_ready`  in  1  IF accepts the redirect this cycle.
- `redirect_valid`  out  1  registered redirect request.
- `redirect_pc`  out  XLEN  registered correct next PC.
- `flush_if_id`, `flush_id_ex`  out  1 each  kill the wrong-path pipeline registers.
- `busy`  out  1  high while in the `PEND` state.
- `br_count`, `mispred_count`  out  CNT_W each  performance counters.

## Operation
- Control-flow instruction: `cf = ex_valid & (ex_is_b_type | ex_is_jal | ex_is_jalr)`.
- Actual direction: `act_taken = ex_is_jal | ex_is_jalr | ex_branch_taken`.
- Correct next PC: `act_taken ? ex_target : ex_pc + 4`. The addition is modulo 2^XLEN, so 0xFFFF_FFFC + 4 = 0x0000_0000.
- Misprediction: `mis = cf & ~resolved & (act_taken != ex_pred_taken | (act_taken & ex_pred_target != ex_target))`.
- `resolved` is an internal flag:
  - Set when `mis` fires while `ex_hold` = 1.
  - Cleared when `ex_hold` = 0.
  - Purpose: a stalled branch triggers exactly one redirect.
- The FSM has two states, `IDLE` and `PEND`.
- In `IDLE`:
  - `mis` → capture the correct next PC into `redirect_pc`, set `redirect_valid`, go to `PEND`.
  - Otherwise stay in `IDLE`.
- In `PEND`:
  - `redirect_valid` stays high and `redirect_pc` is stable.
  - `redirect_ready` = 1 → clear `redirect_valid`, go to `IDLE`.
  - `mis` is ignored in `PEND`, because EX holds wrong-path or bubble content.
- Flush outputs (combinational):
  - `flush_id_ex = mis` in `IDLE`.
  - `flush_if_id = mis | (state == PEND)`.
- `busy = (state == PEND)`.

## Timing
- Reset values:
  - `redirect_valid` = 0, `redirect_pc` = 0, `busy` = 0, state = `IDLE`, `resolved` = 0, counters = 0.
  - Flush outputs are 0 because they are derived from reset state.
- Misprediction in EX at cycle N:
  - `flush_if_id` and `flush_id_ex` are high in cycle N.
  - `redirect_valid` is high from N+1.
- Minimum occupancy of `PEND` is one cycle; with `redirect_ready` tied high, `redirect_valid` is a single-cycle pulse at N+1.
- Handshake: the transfer happens on the edge where `redirect_valid & redirect_ready`. `redirect_pc` must not change while `redirect_valid` is high and unaccepted.
- Back-to-back: a misprediction in the cycle immediately after acceptance (state already `IDLE`) is handled normally.
- `rst` asserted in `PEND` drops `redirect_valid` on the next edge; the redirect is discarded.
- Non-control-flow instruction, or `ex_valid` = 0: no flush and no state change.

## Configuration
- Macro: `BRANCH_PERF_CNT_EN`.
- Defined:
  - `br_count` increments once per `cf` instruction, counted on the cycle where `ex_hold` = 0.
  - `mispred_count` increments once per `mis`.
  - Both wrap at 2^CNT_W and clear on `rst`.
- Undefined: no counter registers are built, and both outputs are tied to 0.

## Test plan
- BEQ at `ex_pc` 0x100, taken, `ex_pred_taken` = 0, `ex_target` 0x140:
  - Both flushes high in cycle N.
  - `redirect_valid` = 1 with `redirect_pc` 0x140 at N+1.
  - `redirect_ready` = 1 → `busy` = 0 at N+2.
- BNE not taken, predicted taken, `ex_pc` 0xFFFF_FFFC → `redirect_pc` 0x0000_0000.
- JALR predicted taken to 0x200, actual target 0x204 → misprediction; `redirect_pc` 0x204.
- `redirect_ready` held low for 3 cycles:
  - `redirect_valid`, `flush_if_id` and `busy` stay high.
  - `redirect_pc` stays stable.
  - A second `mis` during this time is ignored.
- Mispredicted branch with `ex_hold` = 1 for 4 cycles → exactly one redirect, and `mispred_count` increments by 1 (macro on).
- `rst` in `PEND` → next cycle `redirect_valid` = 0, state `IDLE`, counters 0.
